uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 434, sys_clk cycles per baud tick (at least 2).
REQ-002 Parameter FRAME_TICKS, default 10, tx_clk_en pulses per transmitted frame (start + 8 data + stop).
REQ-003 Parameter LOCK_TIMEOUT, default 16, idle baud ticks after which a held lock is released.
REQ-004 sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  4  per-requester byte-valid; requester i is bit i.
REQ-007 req_data  input  32  packed bytes; requester i at [8i+7:8i].
REQ-008 req_lock  input  4  requester i asks to keep the grant after this byte.
REQ-009 req_ready  output  4  one-hot accept strobe; transfer when req_valid[i] and req_ready[i] are both high.
REQ-010 tx_clk_en  output  1  baud tick to the transmitter, one sys_clk cycle wide.
REQ-011 tx_en  output  1  start-frame pulse to the transmitter, one cycle wide.
REQ-012 tx_data  output  8  byte to the transmitter, stable for the whole frame.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 grant_id  output  2  index of the most recently accepted requester.

Function
REQ-015 Baud divider: counter runs 0..CLK_DIV-1 and wraps to 0; tx_clk_en is high only in the cycle where counter == CLK_DIV-1; it is free-running and independent of FSM state.
REQ-016 FSM states: IDLE, SEND, WAIT.
REQ-017 IDLE arbitration is round-robin over the set of valid requesters.
  - Search starts at index rr_ptr and wraps modulo 4.
  - While lock_active, only lock_owner is eligible.
REQ-018 In IDLE, req_ready is combinational: it is high for the selected requester only, in the same cycle its req_valid is high; it is never high outside IDLE.
REQ-019 On a transfer in cycle T:
  - tx_data <= the selected byte;
  - grant_id <= selected index g;
  - rr_ptr <= (g+1) mod 4;
  - state <= SEND.
REQ-020 SEND lasts exactly one cycle.
  - tx_en is registered and high only in cycle T+1.
  - The beat counter is cleared.
  - The next state is WAIT.
REQ-021 WAIT: each tx_clk_en pulse increments the beat counter.
  - On the pulse that makes it FRAME_TICKS, next state is IDLE.
  - A tx_clk_en coincident with SEND is not counted.
REQ-022 tx_data changes only on an accepted transfer; it is held through SEND, WAIT and the following IDLE.
REQ-023 Lock set: a transfer with req_lock[g]=1 sets lock_active=1 and lock_owner=g.
REQ-024 Lock release by the owner: a transfer by the owner with req_lock[g]=0 clears lock_active.
REQ-025 Lock timeout: in IDLE with lock_active and req_valid[lock_owner]=0, each tx_clk_en increments lock_idle.
  - On reaching LOCK_TIMEOUT, lock_active clears.
  - lock_idle clears on any transfer or on leaving IDLE.
REQ-026 The byte accepted in the timeout cycle itself is arbitrated with the old lock; the new eligibility takes effect the next cycle.
REQ-027 No requester valid in IDLE: the FSM stays in IDLE, req_ready=0, tx_en=0.
REQ-028 Input changes while busy (req_valid, req_data, req_lock) have no effect until the return to IDLE.
REQ-029 Back-to-back frames: a transfer is permitted in the first IDLE cycle after WAIT; the minimum spacing between tx_en pulses is therefore FRAME_TICKS baud ticks plus 2 cycles.
REQ-030 busy = (state != IDLE), driven from registered state.

Reset
REQ-031 While rst is high at a clock edge, the following values load:
  - state=IDLE, divider=0, beat=0;
  - rr_ptr=0, lock_active=0, lock_owner=0, lock_idle=0;
  - tx_en=0, tx_data=8'h00, grant_id=0.
REQ-032 During reset, req_ready=0, tx_clk_en=0 and busy=0.
REQ-033 Reset mid-frame (SEND or WAIT) abandons the frame immediately and emits no further tx_en; transmitter recovery is the transmitter's responsibility.

Verification (CLK_DIV=4, FRAME_TICKS=10, LOCK_TIMEOUT=3)
REQ-034 Release rst, no requests:
  - tx_clk_en pulses every 4th cycle, first at cycle 3 after release;
  - busy=0 and tx_en=0 throughout.
REQ-035 Requester 2 only, byte 8'hA5 accepted at cycle T:
  - req_ready=4'b0100 at T;
  - tx_en=1 and tx_data=8'hA5 at T+1;
  - grant_id=2;
  - busy falls after the 10th tx_clk_en following T+1.
REQ-036 All four requesters valid continuously, no lock: grant order is 0,1,2,3,0 and each tx_data matches its requester's byte.
REQ-037 Requester 1 sends 8'h11 (lock=1), then 8'h22 (lock=1), then 8'h33 (lock=0), with requester 0 valid throughout:
  - sequence is 11,22,33, then requester 0's byte;
  - requester 0 is never readied while the lock is active.
REQ-038 Requester 3 sends with lock=1, then drops req_valid while requester 0 is valid:
  - no grant for 3 baud ticks in IDLE;
  - requester 0 is granted after the lock times out.
REQ-039 Assert rst for 1 cycle mid-WAIT:
  - next cycle busy=0, tx_data=8'h00, grant_id=0;
  - the next request is accepted from a fresh round-robin start (requester 0 first).

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake and transmitter-side control bundle for uart_tx_scheduler.
// master = requesters/transmitter environment, slave = the scheduler.
interface uart_tx_scheduler_if;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic        tx_clk_en;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    modport master (
        output req_valid, req_data, req_lock,
        input  req_ready, tx_clk_en, tx_en, tx_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, req_lock,
        output req_ready, tx_clk_en, tx_en, tx_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler in front of a UART transmitter, with per-requester
// grant locking (released by owner or by idle timeout) and a free-running baud divider.
module uart_tx_scheduler #(
    parameter int unsigned CLK_DIV      = 434,
    parameter int unsigned FRAME_TICKS  = 10,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic               sys_clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BEAT_W = $clog2(FRAME_TICKS + 1);
    localparam int unsigned IDLE_W = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                lock_active_q, lock_active_d;
    logic [IDX_W-1:0]    lock_owner_q, lock_owner_d;
    logic [IDLE_W-1:0]   lock_idle_q, lock_idle_d;
    logic                tx_en_q, tx_en_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;

    logic                tick_c;
    logic [NREQ-1:0]     elig_c;
    logic                sel_found_c;
    logic [IDX_W-1:0]    sel_idx_c;
    logic [IDX_W-1:0]    cand_c;
    logic [NREQ-1:0]     req_ready_c;

    // Free-running baud divider, independent of the FSM.
    assign tick_c = (div_q == DIV_W'(CLK_DIV - 1)) && !rst;
    assign div_d  = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : DIV_W'(div_q + 1'b1);

    // Round-robin pick starting at rr_ptr; a held lock narrows eligibility to its owner.
    always_comb begin
        elig_c      = lock_active_q ? (bus.req_valid & (NREQ'(1) << lock_owner_q)) : bus.req_valid;
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        cand_c      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_c = IDX_W'(rr_ptr_q + IDX_W'(k));
            if (!sel_found_c && elig_c[cand_c]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = cand_c;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        rr_ptr_d      = rr_ptr_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        lock_idle_d   = lock_idle_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        tx_en_d       = 1'b0;
        req_ready_c   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_found_c) begin
                    req_ready_c   = NREQ'(1) << sel_idx_c;
                    tx_data_d     = bus.req_data[{sel_idx_c, 3'b000} +: BYTE_W];
                    grant_id_d    = sel_idx_c;
                    rr_ptr_d      = IDX_W'(sel_idx_c + 1'b1);
                    lock_active_d = bus.req_lock[sel_idx_c];
                    if (bus.req_lock[sel_idx_c]) begin
                        lock_owner_d = sel_idx_c;
                    end
                    lock_idle_d   = '0;
                    tx_en_d       = 1'b1;
                    state_d       = ST_SEND;
                end else if (lock_active_q && tick_c && !bus.req_valid[lock_owner_q]) begin
                    // Owner has gone quiet: count idle baud ticks toward releasing the lock.
                    if (lock_idle_q == IDLE_W'(LOCK_TIMEOUT - 1)) begin
                        lock_active_d = 1'b0;
                        lock_idle_d   = '0;
                    end else begin
                        lock_idle_d = IDLE_W'(lock_idle_q + 1'b1);
                    end
                end
            end
            ST_SEND: begin
                beat_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick_c) begin
                    beat_d = BEAT_W'(beat_q + 1'b1);
                    if (beat_q == BEAT_W'(FRAME_TICKS - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            beat_q        <= '0;
            rr_ptr_q      <= '0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
            lock_idle_q   <= '0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= '0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            beat_q        <= beat_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            lock_idle_q   <= lock_idle_d;
            tx_en_q       <= tx_en_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign bus.req_ready = rst ? '0 : req_ready_c;
    assign bus.tx_clk_en = tick_c;
    assign bus.tx_en     = tx_en_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = (state_q != ST_IDLE) && !rst;
    assign bus.grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (CLK_DIV=4, FRAME_TICKS=10, LOCK_TIMEOUT=3):
// a table of single-arbitration vectors plus hand sequences for frame timing, locking and reset.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    uart_tx_scheduler_if bus_if ();

    uart_tx_scheduler #(
        .CLK_DIV      (4),
        .FRAME_TICKS  (10),
        .LOCK_TIMEOUT (3)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic        exp_txen;
        logic [7:0]  exp_data;
        logic [1:0]  exp_gid;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_lock  = '0;
        bus_if.req_data  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Steps until tx_en is seen; reports grant, byte, readies seen and idle activity on the way.
    task automatic wait_grant(input int unsigned bound, output logic [1:0] g, output logic [7:0] d,
                              output logic [3:0] rdy_or, output int unsigned idle_cyc,
                              output int unsigned idle_ticks, output bit ok);
        ok = 1'b0; g = '0; d = '0; rdy_or = '0; idle_cyc = 0; idle_ticks = 0;
        for (int unsigned i = 0; i < bound; i++) begin
            step();
            if (bus_if.tx_en === 1'b1) begin
                ok = 1'b1;
                g  = bus_if.grant_id;
                d  = bus_if.tx_data;
                break;
            end
            rdy_or = rdy_or | bus_if.req_ready;
            if (bus_if.busy === 1'b0) begin
                idle_cyc++;
                if (bus_if.tx_clk_en === 1'b1) idle_ticks++;
            end
        end
    endtask

    bit          ok;
    logic [1:0]  g;
    logic [7:0]  d;
    logic [3:0]  ro;
    int unsigned ic, it;
    logic [31:0] word;

    initial begin
        vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 1'b1, 8'hA5, 2'd2};
        vecs[1] = '{4'b1111, 32'h44332211, 4'b0001, 1'b1, 8'h11, 2'd0};
        vecs[2] = '{4'b1010, 32'h44332211, 4'b0010, 1'b1, 8'h22, 2'd1};
        vecs[3] = '{4'b1000, 32'h44332211, 4'b1000, 1'b1, 8'h44, 2'd3};
        vecs[4] = '{4'b0000, 32'h44332211, 4'b0000, 1'b0, 8'h00, 2'd0};
        vecs[5] = '{4'b0110, 32'h9988CC77, 4'b0010, 1'b1, 8'hCC, 2'd1};
        vecs[6] = '{4'b1100, 32'hF0E0D0C0, 4'b0100, 1'b1, 8'hE0, 2'd2};

        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.req_lock  = '0;

        // Reset state, with requests present to show readies are suppressed.
        rst = 1'b1;
        bus_if.req_valid = 4'b1111;
        step();
        step();
        chk("rst_ready", 32'(bus_if.req_ready), 32'h0);
        chk("rst_clk_en", 32'(bus_if.tx_clk_en), 32'h0);
        chk("rst_busy", 32'(bus_if.busy), 32'h0);
        chk("rst_tx_en", 32'(bus_if.tx_en), 32'h0);
        chk("rst_tx_data", 32'(bus_if.tx_data), 32'h0);
        chk("rst_grant", 32'(bus_if.grant_id), 32'h0);

        // Idle after release: baud tick every 4th cycle starting at cycle 3.
        bus_if.req_valid = '0;
        rst = 1'b0;
        begin
            bit quiet = 1'b1;
            for (int c = 0; c < 12; c++) begin
                chk($sformatf("idle_tick_c%0d", c), 32'(bus_if.tx_clk_en), 32'((c % 4) == 3));
                if (bus_if.busy !== 1'b0 || bus_if.tx_en !== 1'b0) quiet = 1'b0;
                step();
            end
            chk("idle_quiet", 32'(quiet), 32'h1);
        end

        // Single-arbitration table, each from a fresh reset (rr_ptr = 0).
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            bus_if.req_valid = vecs[i].valid;
            bus_if.req_data  = vecs[i].data;
            bus_if.req_lock  = '0;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bus_if.req_ready), 32'(vecs[i].exp_ready));
            step();
            bus_if.req_valid = '0;
            chk($sformatf("vec%0d_tx_en", i), 32'(bus_if.tx_en), 32'(vecs[i].exp_txen));
            chk($sformatf("vec%0d_tx_data", i), 32'(bus_if.tx_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_grant", i), 32'(bus_if.grant_id), 32'(vecs[i].exp_gid));
            chk($sformatf("vec%0d_busy", i), 32'(bus_if.busy), 32'(vecs[i].exp_txen));
        end

        // Frame length with a baud tick landing in the SEND cycle; inputs churn while busy.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (bus_if.tx_clk_en === 1'b1) break;
            step();
        end
        step(); step(); step();
        bus_if.req_valid = 4'b0100;
        bus_if.req_data  = 32'h00A50000;
        #1;
        chk("frame_ready", 32'(bus_if.req_ready), 32'h4);
        step();
        chk("frame_tx_en", 32'(bus_if.tx_en), 32'h1);
        chk("frame_tx_data", 32'(bus_if.tx_data), 32'hA5);
        chk("frame_send_tick", 32'(bus_if.tx_clk_en), 32'h1);
        bus_if.req_valid = 4'b1111;
        bus_if.req_data  = 32'hDEADBEEF;
        bus_if.req_lock  = 4'b1111;
        begin
            int unsigned n = 0;
            bit held = 1'b1;
            bit fell = 1'b0;
            for (int i = 0; i < 100; i++) begin
                step();
                if (bus_if.busy === 1'b0) begin
                    fell = 1'b1;
                    break;
                end
                if (bus_if.tx_clk_en === 1'b1) n++;
                if (bus_if.tx_data !== 8'hA5) held = 1'b0;
            end
            chk("frame_busy_fell", 32'(fell), 32'h1);
            chk("frame_tick_count", 32'(n), 32'd10);
            chk("frame_data_held", 32'(held), 32'h1);
            chk("frame_idle_data", 32'(bus_if.tx_data), 32'hA5);
            chk("frame_idle_grant", 32'(bus_if.grant_id), 32'h2);
        end
        step();
        chk("b2b_tx_en", 32'(bus_if.tx_en), 32'h1);
        chk("b2b_grant", 32'(bus_if.grant_id), 32'h3);
        chk("b2b_tx_data", 32'(bus_if.tx_data), 32'hDE);

        // All four valid, no lock: 0,1,2,3,0 with back-to-back frames.
        do_reset();
        word = 32'h43322110;
        bus_if.req_valid = 4'b1111;
        bus_if.req_data  = word;
        for (int i = 0; i < 5; i++) begin
            wait_grant(200, g, d, ro, ic, it, ok);
            chk($sformatf("rr%0d_ok", i), 32'(ok), 32'h1);
            chk($sformatf("rr%0d_grant", i), 32'(g), 32'(i % 4));
            chk($sformatf("rr%0d_data", i), 32'(d), 32'(word[8*(i%4) +: 8]));
            if (i > 0) chk($sformatf("rr%0d_idle_cycles", i), 32'(ic), 32'd1);
        end
        bus_if.req_valid = '0;

        // Lock held by requester 1 across three bytes while requester 0 waits.
        do_reset();
        bus_if.req_valid = 4'b0010;
        bus_if.req_lock  = 4'b0010;
        bus_if.req_data  = 32'h00001100;
        #1;
        chk("lock_first_ready", 32'(bus_if.req_ready), 32'h2);
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("lock11_ok", 32'(ok), 32'h1);
        chk("lock11_data", 32'(d), 32'h11);
        bus_if.req_valid = 4'b0011;
        bus_if.req_data  = 32'h000022E0;
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("lock22_grant", 32'(g), 32'h1);
        chk("lock22_data", 32'(d), 32'h22);
        chk("lock22_readies", 32'(ro), 32'h2);
        bus_if.req_data = 32'h000033E0;
        bus_if.req_lock = 4'b0000;
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("lock33_grant", 32'(g), 32'h1);
        chk("lock33_data", 32'(d), 32'h33);
        chk("lock33_readies", 32'(ro), 32'h2);
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("unlock_grant", 32'(g), 32'h0);
        chk("unlock_data", 32'(d), 32'hE0);
        chk("unlock_readies", 32'(ro), 32'h1);
        bus_if.req_valid = '0;

        // Lock timeout: owner 3 goes quiet, requester 0 waits out 3 idle baud ticks.
        do_reset();
        bus_if.req_valid = 4'b1000;
        bus_if.req_lock  = 4'b1000;
        bus_if.req_data  = 32'h3C000000;
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("to_owner_grant", 32'(g), 32'h3);
        bus_if.req_valid = 4'b0001;
        bus_if.req_lock  = 4'b0000;
        bus_if.req_data  = 32'h0000000A;
        wait_grant(300, g, d, ro, ic, it, ok);
        chk("to_ok", 32'(ok), 32'h1);
        chk("to_grant", 32'(g), 32'h0);
        chk("to_data", 32'(d), 32'h0A);
        chk("to_idle_ticks", 32'(it), 32'd3);
        chk("to_idle_cycles", 32'(ic), 32'd13);
        bus_if.req_valid = '0;

        // One-cycle reset in the middle of WAIT.
        do_reset();
        bus_if.req_valid = 4'b0100;
        bus_if.req_data  = 32'h005A0000;
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("mid_grant", 32'(g), 32'h2);
        bus_if.req_valid = '0;
        for (int i = 0; i < 10; i++) step();
        chk("mid_busy_before", 32'(bus_if.busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy_after", 32'(bus_if.busy), 32'h0);
        chk("mid_tx_data_after", 32'(bus_if.tx_data), 32'h0);
        chk("mid_grant_after", 32'(bus_if.grant_id), 32'h0);
        chk("mid_tx_en_after", 32'(bus_if.tx_en), 32'h0);
        bus_if.req_valid = 4'b1111;
        bus_if.req_data  = 32'h44332211;
        #1;
        chk("mid_fresh_ready", 32'(bus_if.req_ready), 32'h1);
        wait_grant(200, g, d, ro, ic, it, ok);
        chk("mid_fresh_grant", 32'(g), 32'h0);
        chk("mid_fresh_data", 32'(d), 32'h11);
        bus_if.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
